ir_prefetch_buf: RTL and testbench
==================================

// Module: ir_prefetch_buf
// PURPOSE
//   Parametrised instruction register with a DEPTH-entry prefetch queue between ROM and decode.
//   ROM pushes words over a valid/ready handshake. At the fetch T-state the IR loads the queue head.
//   The IR exposes the split opcode/operand fields and a valid flag, with stall and flush (branch) control.
//   Sits between program ROM and the control unit / decoder.
// PARAMETERS
//   INSTR_W      8      instruction word width (bits)
//   OPC_W        4      opcode field width; opcode = IR_out[INSTR_W-1 -: OPC_W]
//   DEPTH        4      prefetch queue entries; power of 2, >= 2
//   FETCH_PHASE  2'b00  Timing_Signal value at which the IR loads
// PORTS
//   clk            in   1                 system clock, rising edge
//   reset          in   1                 asynchronous, active-high reset
//   Timing_Signal  in   2                 T-state from timing generator
//   rom_valid      in   1                 rom_data holds a valid word
//   rom_data       in   INSTR_W           instruction word from ROM
//   rom_ready      out  1                 queue accepts a word this cycle
//   stall          in   1                 hold IR and queue head (pipeline stall)
//   flush          in   1                 discard queue and IR contents (taken branch)
//   IR_out         out  INSTR_W           registered current instruction
//   opcode         out  OPC_W             IR_out upper field
//   operand        out  INSTR_W-OPC_W     IR_out lower field
//   ir_valid       out  1                 IR_out holds a real instruction (not a bubble)
//   q_count        out  $clog2(DEPTH+1)   queue occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (async, immediate, also mid-operation): IR_out=0, ir_valid=0, q_count=0, rd/wr ptrs=0.
//   - rom_ready = (q_count < DEPTH) && !flush. Combinational from registered count.
//   - push = rom_valid && rom_ready. rom_data is written at wr_ptr, wr_ptr+1 mod DEPTH.
//   - load = (Timing_Signal == FETCH_PHASE) && !stall && !flush.
//     - load with q_count>0: IR_out <= mem[rd_ptr], ir_valid <= 1, pop (rd_ptr+1 mod DEPTH).
//     - load with q_count==0: IR_out holds, ir_valid <= 0 (bubble). No bypass.
//     - Min latency: a word pushed at edge N is loadable at the first fetch phase after edge N.
//   - Not load (other T-states or stall=1): IR_out, ir_valid and rd_ptr hold. Pushes still proceed.
//   - q_count next = q_count + push - pop. Simultaneous push+pop leaves count unchanged.
//   - Full: rom_ready=0, so no push even if a pop occurs that cycle. Empty: no pop.
//   - flush=1 (dominates stall/load/push):
//     - at next edge: q_count=0, rd_ptr=wr_ptr=0, ir_valid=0, IR_out=0.
//     - rom_ready=0 that cycle, so the in-flight word is dropped.
//   - opcode/operand are pure slices of IR_out (no extra latency).
//   - Pointer wrap is implicit via log2(DEPTH)-bit pointers.
//   - Queue storage needs no reset; only pointers and count are reset.
// STRUCTURE
//   - Package ir_pkg:
//     - T0..T3 localparams for Timing_Signal.
//     - default INSTR_W/OPC_W.
//     - typedef instr_t [INSTR_W-1:0].
//   - Sub-module ir_fifo:
//     - DEPTH x INSTR_W storage, pointers, count.
//     - push/pop/clear inputs; head/count outputs.
//   - Top holds the IR register, load/flush logic and field slicing.
// TESTING
//   - Reset: assert reset mid-stream with q_count=3 -> q_count=0, ir_valid=0, IR_out=0 immediately.
//   - Fill: push 0xA1,0xB2,0xC3,0xD4 with no fetch phase.
//     -> q_count=4, rom_ready=0, fifth word 0xE5 not accepted.
//   - Order: from full, cycle T0..T3 four times.
//     -> IR_out = 0xA1, 0xB2, 0xC3, 0xD4 at successive T0s; opcode=0xA, operand=0x1 first.
//   - Bubble: empty queue at T0 -> ir_valid=0, IR_out unchanged.
//     Push 0x35 then next T0 -> IR_out=0x35, ir_valid=1.
//   - Stall: stall=1 across T0 with q_count=2 -> IR_out and q_count hold.
//     Concurrent push -> q_count=3.
//   - Flush: flush=1 with q_count=2, rom_valid=1, Timing_Signal=T0.
//     -> q_count=0, ir_valid=0, word dropped.
//     Wrap check: ptrs restart at 0 and 6 more pushes/pops return in order.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared constants and types for the instruction register / prefetch queue.
package ir_pkg;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    localparam int INSTR_W_DEF = 8;
    localparam int OPC_W_DEF   = 4;

    typedef logic [INSTR_W_DEF-1:0] instr_t;

endpackage

// File: rtl/ir_prefetch_buf_if.sv
// ROM-to-prefetch-queue valid/ready word channel.
interface ir_prefetch_buf_if #(
    parameter int INSTR_W = 8
);
    logic               valid;
    logic [INSTR_W-1:0] data;
    logic               ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ir_fifo.sv
// Prefetch queue: DEPTH x WIDTH ring buffer with occupancy count and synchronous clear.
module ir_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full && !clear_i;
    assign do_pop  = pop_i && !empty && !clear_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ir_prefetch_buf.sv
// Instruction register fed from a prefetch queue; loads at the fetch T-state,
// inserts bubbles when the queue is empty, and clears on flush.
module ir_prefetch_buf
    import ir_pkg::*;
#(
    parameter int         INSTR_W     = INSTR_W_DEF,
    parameter int         OPC_W       = OPC_W_DEF,
    parameter int         DEPTH       = 4,
    parameter logic [1:0] FETCH_PHASE = T0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  Timing_Signal,
    ir_prefetch_buf_if.slave            rom,
    input  logic                        stall,
    input  logic                        flush,
    output logic [INSTR_W-1:0]          IR_out,
    output logic [OPC_W-1:0]            opcode,
    output logic [INSTR_W-OPC_W-1:0]    operand,
    output logic                        ir_valid,
    output logic [$clog2(DEPTH+1)-1:0]  q_count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] head;
    logic [CW-1:0]      count;
    logic               push, load, pop;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;

    assign rom.ready = (count < CW'(DEPTH)) && !flush;
    assign push      = rom.valid && rom.ready;
    assign load      = (Timing_Signal == FETCH_PHASE) && !stall && !flush;
    assign pop       = load && (count != '0);

    ir_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i (rom.data),
        .head_o  (head),
        .count_o (count)
    );

    // An empty queue at fetch leaves IR_out as-is but marks it a bubble.
    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            ir_d       = '0;
            ir_valid_d = 1'b0;
        end else if (load) begin
            if (pop) begin
                ir_d       = head;
                ir_valid_d = 1'b1;
            end else begin
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign IR_out   = ir_q;
    assign opcode   = ir_q[INSTR_W-1 -: OPC_W];
    assign operand  = ir_q[INSTR_W-OPC_W-1:0];
    assign ir_valid = ir_valid_q;
    assign q_count  = count;

endmodule

// File: tb/tb_ir_prefetch_buf.sv
// Directed bench for ir_prefetch_buf with hand-computed expectations.
module tb_ir_prefetch_buf;
    import ir_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Timing_Signal;
    logic       stall, flush;
    logic [7:0] IR_out;
    logic [3:0] opcode, operand;
    logic       ir_valid;
    logic [2:0] q_count;

    int n_checks = 0;
    int n_fail   = 0;

    ir_prefetch_buf_if #(.INSTR_W(8)) rom_bus ();

    ir_prefetch_buf #(
        .INSTR_W     (8),
        .OPC_W       (4),
        .DEPTH       (4),
        .FETCH_PHASE (T0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Timing_Signal (Timing_Signal),
        .rom           (rom_bus.slave),
        .stall         (stall),
        .flush         (flush),
        .IR_out        (IR_out),
        .opcode        (opcode),
        .operand       (operand),
        .ir_valid      (ir_valid),
        .q_count       (q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_t(input logic [1:0] ts);
        Timing_Signal = ts;
        step();
    endtask

    task automatic push_word(input logic [7:0] w);
        rom_bus.valid = 1'b1;
        rom_bus.data  = w;
        Timing_Signal = T1;
        step();
        rom_bus.valid = 1'b0;
    endtask

    logic [7:0] order_exp [4];
    logic [7:0] wrap_w [7];

    initial begin
        reset = 1'b1;
        Timing_Signal = T1;
        stall = 1'b0;
        flush = 1'b0;
        rom_bus.valid = 1'b0;
        rom_bus.data  = '0;
        #3;
        chk("rst_count", 32'(q_count), 0);
        chk("rst_valid", 32'(ir_valid), 0);
        chk("rst_ir",    32'(IR_out), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Fill with no fetch phase
        push_word(8'hA1);
        push_word(8'hB2);
        push_word(8'hC3);
        push_word(8'hD4);
        chk("fill_count", 32'(q_count), 4);
        chk("fill_ready", 32'(rom_bus.ready), 0);
        rom_bus.valid = 1'b1;
        rom_bus.data  = 8'hE5;
        idle_t(T2);
        rom_bus.valid = 1'b0;
        chk("fifth_dropped", 32'(q_count), 4);
        chk("fill_ir_held", 32'(IR_out), 0);

        // Drain in order across four T0..T3 rounds
        order_exp[0] = 8'hA1; order_exp[1] = 8'hB2;
        order_exp[2] = 8'hC3; order_exp[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            idle_t(T0);
            chk("order_ir", 32'(IR_out), 32'(order_exp[i]));
            chk("order_count", 32'(q_count), 32'(3 - i));
            if (i == 0) begin
                chk("order_opcode", 32'(opcode), 32'hA);
                chk("order_operand", 32'(operand), 32'h1);
                chk("order_valid", 32'(ir_valid), 1);
            end
            idle_t(T1);
            idle_t(T2);
            idle_t(T3);
            chk("order_hold", 32'(IR_out), 32'(order_exp[i]));
        end

        // Bubble on empty queue, then refill
        idle_t(T0);
        chk("bubble_valid", 32'(ir_valid), 0);
        chk("bubble_ir", 32'(IR_out), 32'hD4);
        push_word(8'h35);
        idle_t(T2);
        idle_t(T3);
        chk("refill_noload", 32'(ir_valid), 0);
        idle_t(T0);
        chk("refill_ir", 32'(IR_out), 32'h35);
        chk("refill_valid", 32'(ir_valid), 1);
        chk("refill_count", 32'(q_count), 0);

        // Stall across T0 with concurrent push
        push_word(8'h11);
        push_word(8'h22);
        chk("pre_stall_count", 32'(q_count), 2);
        stall = 1'b1;
        rom_bus.valid = 1'b1;
        rom_bus.data  = 8'h33;
        idle_t(T0);
        rom_bus.valid = 1'b0;
        stall = 1'b0;
        chk("stall_ir", 32'(IR_out), 32'h35);
        chk("stall_count", 32'(q_count), 3);
        chk("stall_valid", 32'(ir_valid), 1);

        // Asynchronous reset mid-stream
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(q_count), 0);
        chk("async_rst_valid", 32'(ir_valid), 0);
        chk("async_rst_ir", 32'(IR_out), 0);
        step();
        reset = 1'b0;
        Timing_Signal = T1;
        step();

        // Flush drops queue, IR and the in-flight word
        push_word(8'h44);
        push_word(8'h55);
        chk("pre_flush_count", 32'(q_count), 2);
        flush = 1'b1;
        rom_bus.valid = 1'b1;
        rom_bus.data  = 8'h66;
        Timing_Signal = T0;
        #1;
        chk("flush_ready", 32'(rom_bus.ready), 0);
        step();
        flush = 1'b0;
        rom_bus.valid = 1'b0;
        chk("flush_count", 32'(q_count), 0);
        chk("flush_valid", 32'(ir_valid), 0);
        chk("flush_ir", 32'(IR_out), 0);

        // Wrap: six words through the ring with overlapping push+pop
        for (int i = 0; i < 7; i++) wrap_w[i] = 8'h70 + 8'(i);
        push_word(wrap_w[0]);
        for (int i = 0; i < 6; i++) begin
            rom_bus.valid = (i < 5);
            rom_bus.data  = wrap_w[i+1];
            idle_t(T0);
            chk("wrap_ir", 32'(IR_out), 32'(wrap_w[i]));
            chk("wrap_count", 32'(q_count), (i < 5) ? 1 : 0);
        end
        rom_bus.valid = 1'b0;
        idle_t(T0);
        chk("wrap_end_bubble", 32'(ir_valid), 0);
        chk("wrap_end_ir", 32'(IR_out), 32'h75);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
